// File: rtl/vroom_system_pkg.sv
// Shared types and sizing for the vroom system RAM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vroom_system_pkg;

   localparam int RAM_ADDR_W = 13;
   localparam int RAM_WORDS  = 8192;
   localparam int BYTE_LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/vroom_system_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words (lane 0 -> bits 7:0).
// Latency: word_last flags the 4th byte combinationally; the full word is in word_dat the next cycle.
// Backpressure: none; only counts bytes the parent has already accepted (byte_vld = valid & ready).
module vroom_system_byte_packer
   import vroom_system_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic [31:0] word_dat,
   output logic        word_last
);

   localparam int LANE_W = $clog2(BYTE_LANES);

   logic [LANE_W-1:0] lane_q;
   logic [31:0]       word_q;

   // Lane counter and assembly register; clear drops any partial word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (clear) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (byte_vld) begin
         word_q[{lane_q, 3'b000} +: 8] <= byte_dat;
         lane_q                        <= lane_q + LANE_W'(1);
      end
   end

   assign word_dat  = word_q;
   assign word_last = byte_vld && (lane_q == LANE_W'(BYTE_LANES - 1));

endmodule

// File: rtl/vroom_system_ram_loader.sv
// Loads a byte stream into RAM as 32-bit words via an Avalon-MM write master (macro: VROOM_RAM_LOADER_CKSUM_EN adds a word checksum).
// Latency: one word per 5 cycles (4 FILL + 1 WRITE); done pulses the cycle after the last WRITE.
// Backpressure: in_ready is high only in FILL; stalls on in_valid low, RAM write is a fixed single cycle.
module vroom_system_ram_loader
   import vroom_system_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic [31:0]       checksum
);

   localparam int CNT_W = ADDR_W + 1;

   loader_state_t     state_q;
   loader_state_t     state_nxt;

   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  count_q;
   logic [ADDR_W-1:0] index_q;
   logic              wrapped_q;

   logic              start_acc;
   logic              abort_act;
   logic              byte_xfer;
   logic              last_word;
   logic [CNT_W-1:0]  addr_sum;
   logic [31:0]       word_dat;
   logic              word_last;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign abort_act = abort && ((state_q == ST_FILL) || (state_q == ST_WRITE));
   assign byte_xfer = in_valid && in_ready;
   // Carry bit of the widened sum marks an address that ran past the top of RAM.
   assign addr_sum  = {1'b0, base_q} + {1'b0, index_q};
   assign last_word = ({1'b0, index_q} + CNT_W'(1)) == count_q;

   vroom_system_byte_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (start_acc || abort_act),
      .byte_vld  (byte_xfer),
      .byte_dat  (in_data),
      .word_dat  (word_dat),
      .word_last (word_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state: abort beats a completing word; a zero-length load skips straight to DONE.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (word_count == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (word_last) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (last_word) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_FILL;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; RAM signals are held at zero outside WRITE.
   always_comb begin
      in_ready       = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_byteenable = 4'h0;
      ram_address    = '0;
      ram_writedata  = '0;
      case (state_q)
         ST_FILL: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_WRITE: begin
            busy           = 1'b1;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_byteenable = 4'hF;
            ram_address    = addr_sum[ADDR_W-1:0];
            ram_writedata  = word_dat;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Load parameters captured on accepted start; word index and wrap flag advance per WRITE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q    <= '0;
         count_q   <= '0;
         index_q   <= '0;
         wrapped_q <= 1'b0;
      end else if (start_acc) begin
         base_q    <= base_addr;
         count_q   <= word_count;
         index_q   <= '0;
         wrapped_q <= 1'b0;
      end else if (state_q == ST_WRITE) begin
         index_q <= index_q + ADDR_W'(1);
         if (addr_sum[ADDR_W]) begin
            wrapped_q <= 1'b1;
         end
      end
   end

   assign wrapped = wrapped_q;

`ifdef VROOM_RAM_LOADER_CKSUM_EN
   logic [31:0] cksum_q;

   // Running sum of every word written since the last accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cksum_q <= '0;
      end else if (start_acc) begin
         cksum_q <= '0;
      end else if (state_q == ST_WRITE) begin
         cksum_q <= cksum_q + word_dat;
      end
   end

   assign checksum = cksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_vroom_system_ram_loader.sv
// Directed bench for the RAM loader: basic load, wrap, zero count, abort, backpressure, reset, checksum.
// Cycle numbering: the cycle in which start is driven is cycle 0.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_vroom_system_ram_loader;
   import vroom_system_pkg::*;

   localparam int AW = RAM_ADDR_W;
`ifdef VROOM_RAM_LOADER_CKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] ram_address;
   logic [3:0]    ram_byteenable;
   logic          ram_chipselect;
   logic          ram_write;
   logic [31:0]   ram_writedata;
   logic          busy;
   logic          done;
   logic          wrapped;
   logic [31:0]   checksum;

   always #5 clk = ~clk;

   vroom_system_ram_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .busy           (busy),
      .done           (done),
      .wrapped        (wrapped),
      .checksum       (checksum)
   );

   int total = 0;
   int bad   = 0;

   // Monitor state (written only by the monitor processes).
   int            cyc = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            busy_cnt = 0;
   int            strobe_bad = 0;
   logic          wrapped_at_done = 1'b0;
   logic [31:0]   cksum_at_done = '0;

   // Stimulus-side bookkeeping.
   logic [7:0]    byte_tab[8];
   int            start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_write) begin
         wr_addr.push_back(ram_address);
         wr_data.push_back(ram_writedata);
         if (!ram_chipselect || ram_byteenable != 4'hF) strobe_bad++;
      end else if (ram_chipselect || ram_byteenable != 4'h0) begin
         strobe_bad++;
      end
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc        = cyc;
         wrapped_at_done = wrapped;
         cksum_at_done   = checksum;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wa(input int k);
      return (k < wr_addr.size()) ? 32'(wr_addr[k]) : 32'bx;
   endfunction

   function automatic logic [31:0] wd(input int k);
      return (k < wr_data.size()) ? wr_data[k] : 32'bx;
   endfunction

   // Start a load, feed nbytes from byte_tab, optionally abort after abort_at bytes
   // or pulse a stray start on loop iteration stray_at, then let the load drain.
   task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] cnt, input int nbytes,
                           input bit rnd, input int abort_at, input int stray_at);
      int i;
      int guard;
      bit xfer;
      i = 0;
      guard = 0;
      @(posedge clk); #1;
      base_addr  = base;
      word_count = cnt;
      start      = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      while (i < nbytes && guard < 200) begin
         in_data   = byte_tab[i];
         in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = (guard == stray_at);
         base_addr = (guard == stray_at) ? AW'(12'hAAA) : base;
         if (i == abort_at) begin
            abort    = 1'b1;
            in_valid = 1'b0;
         end
         xfer = in_valid && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (abort) begin
            abort = 1'b0;
            break;
         end
         if (xfer) i++;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic set_bytes(input logic [63:0] b);
      for (int k = 0; k < 8; k++) byte_tab[k] = b[8*k +: 8];
   endtask

   initial begin
      int w0;
      int d0;
      int b0;

      // Reset: every output low.
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_ctl", 64'({in_ready, ram_byteenable, ram_chipselect, ram_write,
                                  busy, done, wrapped, ram_address}), 64'h0);
      check_val("reset_data", {ram_writedata, checksum}, 64'h0);
      reset_n = 1'b1;

      // Basic load: bytes 01..08 at base 0x0010, two words, done in cycle 11.
      set_bytes(64'h0807060504030201);
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h0010), 14'd2, 8, 1'b0, -1, -1);
      check_val("basic_nwr",  64'(wr_addr.size() - w0), 64'd2);
      check_val("basic_a0",   wa(w0),     32'h0010);
      check_val("basic_d0",   wd(w0),     32'h04030201);
      check_val("basic_a1",   wa(w0 + 1), 32'h0011);
      check_val("basic_d1",   wd(w0 + 1), 32'h08070605);
      check_val("basic_done", 64'(done_cnt - d0), 64'd1);
      check_val("basic_lat",  64'(done_cyc - start_cyc), 64'd11);
      check_val("basic_wrap", 64'(wrapped_at_done), 64'd0);
      check_val("basic_ck",   cksum_at_done, CK_EN ? 32'h0C0A0806 : 32'h0);
      check_val("basic_idle", 64'({busy, in_ready, done}), 64'd0);

      // Wrap-around: base 0x1FFF, second word lands at 0x0000; wrapped is sticky.
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h1FFF), 14'd2, 8, 1'b0, -1, -1);
      check_val("wrap_nwr",  64'(wr_addr.size() - w0), 64'd2);
      check_val("wrap_a0",   wa(w0),     32'h1FFF);
      check_val("wrap_a1",   wa(w0 + 1), 32'h0000);
      check_val("wrap_d1",   wd(w0 + 1), 32'h08070605);
      check_val("wrap_done", 64'(done_cnt - d0), 64'd1);
      check_val("wrap_flag", 64'(wrapped_at_done), 64'd1);
      check_val("wrap_hold", 64'(wrapped), 64'd1);

      // Zero count: no write, done in the cycle right after start, busy never high, wrap cleared.
      w0 = wr_addr.size(); d0 = done_cnt; b0 = busy_cnt;
      run_load(AW'(16'h0123), 14'd0, 0, 1'b0, -1, -1);
      check_val("zero_nwr",  64'(wr_addr.size() - w0), 64'd0);
      check_val("zero_done", 64'(done_cnt - d0), 64'd1);
      check_val("zero_lat",  64'(done_cyc - start_cyc), 64'd1);
      check_val("zero_busy", 64'(busy_cnt - b0), 64'd0);
      check_val("zero_wrap", 64'(wrapped_at_done), 64'd0);

      // Abort after two bytes of word 1: nothing written, no done, back to idle.
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h0040), 14'd2, 8, 1'b0, 2, -1);
      check_val("abort_nwr",  64'(wr_addr.size() - w0), 64'd0);
      check_val("abort_done", 64'(done_cnt - d0), 64'd0);
      check_val("abort_idle", 64'({busy, in_ready}), 64'd0);

      // Fresh start after abort: partial word must be gone.
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h0040), 14'd2, 8, 1'b0, -1, -1);
      check_val("reab_a0",   wa(w0),     32'h0040);
      check_val("reab_d0",   wd(w0),     32'h04030201);
      check_val("reab_a1",   wa(w0 + 1), 32'h0041);
      check_val("reab_d1",   wd(w0 + 1), 32'h08070605);
      check_val("reab_done", 64'(done_cnt - d0), 64'd1);

      // Random in_valid plus a stray start (base 0x0AAA) mid-load: same result as continuous.
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h0010), 14'd2, 8, 1'b1, -1, 3);
      check_val("bp_nwr",  64'(wr_addr.size() - w0), 64'd2);
      check_val("bp_a0",   wa(w0),     32'h0010);
      check_val("bp_d0",   wd(w0),     32'h04030201);
      check_val("bp_a1",   wa(w0 + 1), 32'h0011);
      check_val("bp_d1",   wd(w0 + 1), 32'h08070605);
      check_val("bp_done", 64'(done_cnt - d0), 64'd1);

      // Reset mid-load: partial word dropped, no write or done afterwards.
      w0 = wr_addr.size(); d0 = done_cnt;
      @(posedge clk); #1;
      base_addr = AW'(16'h0100); word_count = 14'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #2;
      check_val("rst_mid_outs", 64'({in_ready, busy, done, ram_write, ram_chipselect}), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("rst_mid_nwr",  64'(wr_addr.size() - w0), 64'd0);
      check_val("rst_mid_done", 64'(done_cnt - d0), 64'd0);

      // Checksum: 0xFFFFFFFF + 0x00000002 wraps to 0x00000001.
      set_bytes(64'h00000002FFFFFFFF);
      w0 = wr_addr.size(); d0 = done_cnt;
      run_load(AW'(16'h0200), 14'd2, 8, 1'b0, -1, -1);
      check_val("ck_d0",   wd(w0),     32'hFFFFFFFF);
      check_val("ck_d1",   wd(w0 + 1), 32'h00000002);
      check_val("ck_done", 64'(done_cnt - d0), 64'd1);
      check_val("ck_sum",  cksum_at_done, CK_EN ? 32'h00000001 : 32'h0);

      // RAM strobes must only ever appear together, and only while writing.
      check_val("strobes", 64'(strobe_bad), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
